// File: rtl/spi_reg_bank_pkg.sv
// spi_reg_bank_pkg: shared state encoding and constants for the SPI register bank
package spi_reg_bank_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  localparam int RW_MSB_OFS = 1;
  localparam int DEF_TIMEOUT_CYC = 64;
endpackage

// File: rtl/spi_reg_bank_edge.sv
// spi_edge_sync: two-flop sclk synchroniser plus a third flop for edge detection
module spi_edge_sync (
  input  logic iclk,
  input  logic rst,
  input  logic sclk,
  output logic rise_pulse,
  output logic fall_pulse
);
  logic [2:0] r_sync;
  always_ff @(posedge iclk or posedge rst)
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[1:0], sclk};
  assign rise_pulse = r_sync[1] & ~r_sync[2];
  assign fall_pulse = ~r_sync[1] & r_sync[2];
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-addressed register bank with burst read/write, read-only slots and frame timeout
module spi_reg_bank import spi_reg_bank_pkg::*; #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                         iclk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         serial_in,
  output logic                         serial_out,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_data,
  output logic [NUM_REGS*DATA_W-1:0]   reg_data,
  output logic                         wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0]  wr_addr,
  output logic                         busy,
  output logic                         frame_err
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int BW = $clog2(DATA_W);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t r_state, w_next;
  logic [BW-1:0] r_bitcnt;
  logic [DATA_W-2:0] r_sh_in;
  logic [DATA_W-1:0] r_sh_out, w_word;
  logic [AW-1:0] r_ptr, w_ptr_inc, r_wr_addr;
  logic [TW-1:0] r_tmo;
  logic r_rw, r_so, r_ferr, r_wr_strobe, w_rise, w_fall, w_last, w_timeout;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  spi_edge_sync u_sync (.iclk(iclk), .rst(rst), .sclk(sclk), .rise_pulse(w_rise), .fall_pulse(w_fall));
  function automatic logic [DATA_W-1:0] rd_word(input logic [AW-1:0] a);
    return RO_MASK[a] ? ro_data[a*DATA_W +: DATA_W] : r_regs[a];
  endfunction
  assign w_word = {r_sh_in, serial_in};
  assign w_last = r_bitcnt == BW'(DATA_W - 1);
  assign w_ptr_inc = (r_ptr == AW'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
  // a commit needs an sclk edge, which also clears the counter, so commit and timeout never coincide
  assign w_timeout = r_state != IDLE && !(w_rise || w_fall) && r_tmo == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge iclk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = w_timeout ? IDLE : !w_rise ? r_state : (r_state == IDLE) ? CMD :
             (r_state == CMD && w_last) ? DATA : r_state;
  end
  always_comb begin
    busy = r_state != IDLE;
    serial_out = r_so && r_state == DATA && r_rw;
  end
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_sh_in <= '0;
      r_sh_out <= '0;
      r_ptr <= '0;
      r_rw <= 1'b0;
      r_so <= 1'b0;
      r_tmo <= '0;
      r_ferr <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_tmo <= (w_rise || w_fall) ? '0 : (r_tmo == TW'(TIMEOUT_CYC)) ? r_tmo : r_tmo + 1'b1;
      if (w_timeout) begin
        r_ferr <= r_bitcnt != '0;
        r_bitcnt <= '0;
        r_so <= 1'b0;
      end else if (w_rise) begin
        r_sh_in <= w_word[DATA_W-2:0];
        r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
        if (r_state == IDLE) r_ferr <= 1'b0;
        if (r_state == CMD && w_last) begin
          r_rw <= w_word[DATA_W-RW_MSB_OFS];
          r_ptr <= w_word[AW-1:0];
          r_sh_out <= rd_word(w_word[AW-1:0]);
        end
        if (r_state == DATA && w_last) begin
          r_ptr <= w_ptr_inc;
          if (r_rw) r_sh_out <= rd_word(w_ptr_inc);
          else if (!RO_MASK[r_ptr]) begin
            r_regs[r_ptr] <= w_word;
            r_wr_strobe <= 1'b1;
            r_wr_addr <= r_ptr;
          end
        end
      end else if (w_fall && r_state == DATA && r_rw) begin
        r_so <= r_sh_out[DATA_W-1];
        r_sh_out <= r_sh_out << 1;
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_data[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : r_regs[i];
  end
  assign wr_strobe = r_wr_strobe;
  assign wr_addr = r_wr_addr;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed SPI frames against a register model and a write/read scoreboard
module tb_spi_reg_bank;
  localparam int HALF = 8;
  localparam int TMO = 64;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, serial_in = 1'b0;
  logic serial_out, wr_strobe, busy, frame_err;
  logic [2:0] wr_addr;
  logic [63:0] reg_data;
  logic [63:0] ro_data = {8'h80, 8'h70, 8'h60, 8'h50, 8'h5C, 8'h30, 8'h20, 8'h10};
  logic [7:0] m_regs [8];
  logic [11:0] wr_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] rx;
  int n_tests = 0, n_fail = 0;

  spi_reg_bank #(.RO_MASK(8'h08)) dut (
    .iclk(clk), .rst(rst), .sclk(sclk), .serial_in(serial_in), .serial_out(serial_out),
    .ro_data(ro_data), .reg_data(reg_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int k = 0; k < 8; k++) f[k*8 +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic tick();
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (wr_strobe) begin
      e = 12'h0;
      if (wr_q.size() != 0) e = wr_q.pop_front();
      chk("wr_strobe_addr_data", {1'b1, wr_addr, reg_data[wr_addr*8 +: 8]}, e);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = '0;
    for (int b = 7; b > 7 - n; b--) begin
      serial_in = tx[b];
      repeat (HALF) tick();
      r[b] = serial_out;
      sclk = 1'b1;
      repeat (HALF) tick();
      sclk = 1'b0;
    end
  endtask

  task automatic wr_word(input logic [2:0] a, input logic [7:0] d);
    wr_q.push_back({1'b1, a, d});
    m_regs[a] = d;
    spi_bits(d, 8, rx);
  endtask

  task automatic end_frame();
    serial_in = 1'b0;
    repeat (TMO + 8) tick();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m_regs[k] = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_serial_out", serial_out, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_reg_data", reg_data, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_busy", busy, 0);

    spi_bits(8'h02, 8, rx);
    chk("wr_busy_mid", busy, 1);
    chk("wr_cmd_serial_out", rx, 0);
    wr_word(3'd2, 8'hA5);
    end_frame();
    chk("wr_done_busy", busy, 0);
    chk("wr_done_ferr", frame_err, 0);
    chk("wr_strobes_seen", wr_q.size(), 0);
    chk("wr_reg_data", reg_data, model_flat());

    spi_bits(8'h06, 8, rx);
    wr_word(3'd6, 8'h11);
    wr_word(3'd7, 8'h22);
    wr_word(3'd0, 8'h33);
    end_frame();
    chk("burst_strobes_seen", wr_q.size(), 0);
    chk("burst_reg_data", reg_data, model_flat());

    spi_bits(8'h04, 8, rx);
    wr_word(3'd4, 8'h3C);
    end_frame();
    rd_q.push_back(8'h5C);
    rd_q.push_back(m_regs[4]);
    spi_bits(8'h83, 8, rx);
    chk("rd_cmd_serial_out", rx, 0);
    spi_bits(8'h00, 8, rx);
    chk("rd_word0_ro", rx, rd_q.pop_front());
    spi_bits(8'h00, 8, rx);
    chk("rd_word1_reg4", rx, rd_q.pop_front());
    end_frame();
    chk("rd_idle_serial_out", serial_out, 0);
    chk("rd_no_side_effect", reg_data, model_flat());

    spi_bits(8'h03, 8, rx);
    spi_bits(8'hFF, 8, rx);
    end_frame();
    chk("ro_no_strobe", wr_q.size(), 0);
    chk("ro_reg_data", reg_data, model_flat());
    chk("ro_slot_zero", reg_data[31:24], 0);

    spi_bits(8'h01, 8, rx);
    spi_bits(8'hC0, 4, rx);
    repeat (TMO - 4) tick();
    chk("tmo_still_busy", busy, 1);
    repeat (10) tick();
    chk("tmo_busy", busy, 0);
    chk("tmo_frame_err", frame_err, 1);
    chk("tmo_no_commit", reg_data, model_flat());
    spi_bits(8'h05, 8, rx);
    chk("tmo_err_cleared", frame_err, 0);
    wr_word(3'd5, 8'h77);
    end_frame();
    chk("post_tmo_reg_data", reg_data, model_flat());

    spi_bits(8'h01, 8, rx);
    wr_word(3'd1, 8'h12);
    spi_bits(8'h34, 4, rx);
    rst = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) m_regs[k] = '0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_strobe", wr_strobe, 0);
    chk("mid_rst_serial_out", serial_out, 0);
    chk("mid_rst_reg_data", reg_data, 0);
    rst = 1'b0;
    repeat (4) tick();
    spi_bits(8'h07, 8, rx);
    wr_word(3'd7, 8'h9E);
    end_frame();
    chk("after_rst_strobes", wr_q.size(), 0);
    chk("after_rst_reg_data", reg_data, model_flat());
    chk("after_rst_ferr", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
